// File: rtl/axi_burst_gate_pkg.sv
// Shared definitions for the burst gate and the DDR write engine that consumes its commands.
// State encoding and the command word layout {len-1, byte_addr}.
package axi_burst_gate_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Beat/occupancy counters are sized to match the upstream FIFO reporting.
    localparam int CNT_W = 18;
    localparam int LEN_W = 8;

    // The length field sits directly above the byte address.
    function automatic int len_lsb(input int awidth);
        return awidth;
    endfunction

endpackage

// File: rtl/axi_burst_gate_if.sv
// Handshake bundle for the burst gate: upstream FIFO stream, DDR command and DDR write data.
// master = the gate itself, slave = its surroundings (FIFO + DDR writer).
interface axi_burst_gate_if
    import axi_burst_gate_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 32
) ();

    logic [WIDTH-1:0]        i_tdata;
    logic                    i_tvalid;
    logic                    i_tready;

    logic [AWIDTH+LEN_W-1:0] cmd_tdata;
    logic                    cmd_tvalid;
    logic                    cmd_tready;

    logic [WIDTH-1:0]        o_tdata;
    logic                    o_tlast;
    logic                    o_tvalid;
    logic                    o_tready;

    modport master (
        input  i_tdata, i_tvalid, cmd_tready, o_tready,
        output i_tready, cmd_tdata, cmd_tvalid, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        output i_tdata, i_tvalid, cmd_tready, o_tready,
        input  i_tready, cmd_tdata, cmd_tvalid, o_tdata, o_tlast, o_tvalid
    );

endinterface

// File: rtl/axi_burst_gate.sv
// Groups a FIFO stream into DDR write bursts: one command, then exactly len beats with tlast.
// Latency: command one cycle after trigger; data is a zero-latency pass-through while bursting.
// Backpressure: cmd_tready holds the command stable; o_tready feeds straight back to i_tready.
module axi_burst_gate
    import axi_burst_gate_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int AWIDTH  = 32,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [AWIDTH-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_words,
    input  logic [CNT_W-1:0]  fifo_occupied,
    axi_burst_gate_if.master  bus,
    output logic [15:0]       bursts_done
);

    localparam int TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LEN_LSB = len_lsb(AWIDTH);
    localparam logic [AWIDTH-1:0] STEP = AWIDTH'(WIDTH / 8);

    logic [1:0]              state;
    logic [TW-1:0]           tcnt;
    logic [CNT_W-1:0]        offset;
    logic [CNT_W-1:0]        words_q;
    logic [CNT_W-1:0]        len;
    logic [CNT_W-1:0]        remain;
    logic [AWIDTH+LEN_W-1:0] cmd_dat;
    logic                    cmd_vld;

    logic [CNT_W-1:0]        eff_off;
    logic [CNT_W-1:0]        room;
    logic [CNT_W-1:0]        want;
    logic [CNT_W-1:0]        len_n;
    logic [CNT_W-1:0]        off_sum;
    logic [AWIDTH-1:0]       addr_n;
    logic                    trig;
    logic                    in_data;
    logic                    beat;

    // A stale offset beyond a shrunken region restarts at the region base.
    always_comb begin
        eff_off = (offset >= cfg_words) ? '0 : offset;
        room    = cfg_words - eff_off;
        if (fifo_occupied >= CNT_W'(BURST)) begin
            want = CNT_W'(BURST);
        end else if (fifo_occupied == '0) begin
            want = CNT_W'(1);
        end else begin
            want = fifo_occupied;
        end
        len_n   = (want > room) ? room : want;
        off_sum = offset + len;
    end

    assign trig    = (fifo_occupied >= CNT_W'(BURST)) || (tcnt == TW'(TIMEOUT));
    assign addr_n  = cfg_base_addr + AWIDTH'(eff_off) * STEP;
    assign in_data = (state == ST_DATA);
    assign beat    = in_data && bus.i_tvalid && bus.o_tready;

    assign bus.cmd_tdata  = cmd_dat;
    assign bus.cmd_tvalid = cmd_vld;
    assign bus.o_tdata    = bus.i_tdata;
    assign bus.o_tvalid   = in_data && bus.i_tvalid;
    assign bus.i_tready   = in_data && bus.o_tready;
    assign bus.o_tlast    = in_data && (remain == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            offset      <= '0;
            words_q     <= '0;
            len         <= '0;
            remain      <= '0;
            cmd_dat     <= '0;
            cmd_vld     <= 1'b0;
            bursts_done <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_words == '0 || !bus.i_tvalid) begin
                        tcnt <= '0;
                    end else if (trig) begin
                        len                          <= len_n;
                        remain                       <= len_n;
                        offset                       <= eff_off;
                        words_q                      <= cfg_words;
                        cmd_dat[LEN_LSB +: LEN_W]    <= LEN_W'(len_n - CNT_W'(1));
                        cmd_dat[LEN_LSB-1:0]         <= addr_n;
                        cmd_vld                      <= 1'b1;
                        state                        <= ST_CMD;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_CMD: begin
                    if (cmd_vld && bus.cmd_tready) begin
                        cmd_vld <= 1'b0;
                        tcnt    <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        remain <= remain - CNT_W'(1);
                        if (remain == CNT_W'(1)) begin
                            offset      <= (off_sum >= words_q) ? '0 : off_sum;
                            bursts_done <= bursts_done + 16'd1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_gate.sv
// Directed bench for axi_burst_gate: command addresses/lengths, burst framing, timeout flush,
// region clipping, backpressure, mid-burst clear and disabled region.
module tb_axi_burst_gate;

    localparam int W     = 32;
    localparam int AW    = 32;
    localparam int BURST = 16;
    localparam int TMO   = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [AW-1:0] cfg_base_addr;
    logic [17:0]   cfg_words;
    logic [17:0]   fifo_occupied;
    logic [15:0]   bursts_done;

    axi_burst_gate_if #(.WIDTH(W), .AWIDTH(AW)) bus ();

    axi_burst_gate #(.WIDTH(W), .AWIDTH(AW), .BURST(BURST), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .cfg_base_addr (cfg_base_addr),
        .cfg_words     (cfg_words),
        .fifo_occupied (fifo_occupied),
        .bus           (bus),
        .bursts_done   (bursts_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source / sink / command recorder state
    logic [31:0]    seq;
    bit             adv, src_en, rand_rdy, cmd_held;
    int             cmd_delay, cmd_wait, beat_cnt;
    int             loss_err, data_err, stab_err, excl_err;
    logic [AW+7:0]  cmd_prev;
    logic [AW-1:0]  cmd_addr_q[$];
    int             cmd_len_q[$];
    int             cmd_bd_q[$];
    int             burst_q[$];

    task automatic rec_clear();
        cmd_addr_q.delete(); cmd_len_q.delete(); cmd_bd_q.delete(); burst_q.delete();
        beat_cnt = 0; cmd_held = 0; cmd_wait = 0;
        loss_err = 0; data_err = 0; stab_err = 0; excl_err = 0;
    endtask

    // Drive at negedge, then observe the handshakes that the next posedge will commit.
    task automatic step();
        @(negedge clk);
        if (adv) begin seq = seq + 1; adv = 0; end
        bus.i_tdata    = seq;
        bus.i_tvalid   = src_en;
        bus.o_tready   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.cmd_tready = (cmd_wait >= cmd_delay);
        #1;
        if (bus.cmd_tvalid && bus.o_tvalid) excl_err++;
        if ((bus.i_tvalid && bus.i_tready) != (bus.o_tvalid && bus.o_tready)) loss_err++;
        if (bus.cmd_tvalid) begin
            if (cmd_held && bus.cmd_tdata !== cmd_prev) stab_err++;
            cmd_prev = bus.cmd_tdata;
            if (bus.cmd_tready) begin
                cmd_addr_q.push_back(bus.cmd_tdata[AW-1:0]);
                cmd_len_q.push_back(int'(bus.cmd_tdata[AW +: 8]));
                cmd_bd_q.push_back(int'(bursts_done));
                cmd_held = 0;
                cmd_wait = 0;
            end else begin
                cmd_held = 1;
                cmd_wait++;
            end
        end
        if (bus.o_tvalid && bus.o_tready) begin
            if (bus.o_tdata !== seq) data_err++;
            beat_cnt++;
            if (bus.o_tlast) begin
                burst_q.push_back(beat_cnt);
                beat_cnt = 0;
            end
        end
        if (bus.i_tvalid && bus.i_tready) adv = 1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; src_en = 0; bus.i_tvalid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        rec_clear();
    endtask

    task automatic run_cmds(input int n, input int budget, input string tag);
        for (int c = 0; c < budget && cmd_addr_q.size() < n; c++) step();
        check(tag, cmd_addr_q.size(), n);
    endtask

    task automatic run_bursts(input int n, input int budget, input string tag);
        for (int c = 0; c < budget && burst_q.size() < n; c++) step();
        check(tag, burst_q.size(), n);
    endtask

    logic [AW-1:0] t1_addr [5] = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h1000};
    logic [AW-1:0] t3_addr [3] = '{32'h2000, 32'h2040, 32'h2000};
    int            t3_len  [3] = '{15, 3, 15};
    int            t3_beat [2] = '{16, 4};

    initial begin
        int n, nc, nr;
        reset = 1'b1; clear = 1'b0;
        cfg_base_addr = '0; cfg_words = '0; fifo_occupied = '0;
        bus.i_tdata = '0; bus.i_tvalid = 1'b0; bus.o_tready = 1'b0; bus.cmd_tready = 1'b0;
        seq = 32'hA000_0000; adv = 0; src_en = 0; rand_rdy = 0; cmd_delay = 0;
        rec_clear();

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_tvalid", bus.cmd_tvalid, 0);
        check("rst_o_tvalid",   bus.o_tvalid, 0);
        check("rst_i_tready",   bus.i_tready, 0);
        check("rst_o_tlast",    bus.o_tlast, 0);
        check("rst_cmd_tdata",  bus.cmd_tdata, 0);
        check("rst_bursts",     bursts_done, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full bursts, region wrap after four
        cfg_base_addr = 32'h1000; cfg_words = 18'd64; fifo_occupied = 18'd40; src_en = 1;
        run_cmds(5, 400, "t1_ncmd");
        check("t1_nburst", burst_q.size(), 4);
        if (cmd_addr_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t1_addr%0d", i), cmd_addr_q[i], t1_addr[i]);
                check($sformatf("t1_len%0d", i), cmd_len_q[i], 15);
            end
            check("t1_bd_at_cmd5", cmd_bd_q[4], 4);
        end
        if (burst_q.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("t1_beats%0d", i), burst_q[i], 16);
        check("t1_integrity", data_err + loss_err + excl_err, 0);

        // Timeout flush with an empty-reporting FIFO
        do_clear();
        @(negedge clk);
        fifo_occupied = '0; bus.cmd_tready = 1'b0; bus.i_tdata = seq; bus.i_tvalid = 1'b1; src_en = 1;
        n = 0;
        while (!bus.cmd_tvalid && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("t2_latency", n, 256);
        check("t2_len",     bus.cmd_tdata[AW +: 8], 0);
        check("t2_addr",    bus.cmd_tdata[AW-1:0], 32'h1000);
        rec_clear();
        run_bursts(1, 50, "t2_nburst");
        if (burst_q.size() >= 1) check("t2_single_tlast", burst_q[0], 1);
        step();
        check("t2_bursts_done", bursts_done, 1);

        // Region end clipping
        do_clear();
        cfg_base_addr = 32'h2000; cfg_words = 18'd20; fifo_occupied = 18'd16; src_en = 1;
        run_cmds(3, 300, "t3_ncmd");
        if (cmd_addr_q.size() >= 3)
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t3_addr%0d", i), cmd_addr_q[i], t3_addr[i]);
                check($sformatf("t3_len%0d", i), cmd_len_q[i], t3_len[i]);
            end
        if (burst_q.size() >= 2)
            for (int i = 0; i < 2; i++) check($sformatf("t3_beats%0d", i), burst_q[i], t3_beat[i]);

        // Random data backpressure, slow command acceptance
        do_clear();
        cfg_base_addr = 32'h1000; cfg_words = 18'd64; fifo_occupied = 18'd40; src_en = 1;
        rand_rdy = 1; cmd_delay = 7;
        run_bursts(4, 2000, "t4_nburst");
        if (burst_q.size() >= 4 && cmd_len_q.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t4_beats%0d", i), burst_q[i], 16);
                check($sformatf("t4_addr%0d", i), cmd_addr_q[i], t1_addr[i]);
            end
        check("t4_cmd_stable", stab_err, 0);
        check("t4_no_loss",    loss_err, 0);
        check("t4_data_order", data_err, 0);
        check("t4_exclusive",  excl_err, 0);

        // Clear during beat 5 of the second burst
        do_clear();
        rand_rdy = 0; cmd_delay = 0;
        cfg_base_addr = 32'h3000; cfg_words = 18'd64; fifo_occupied = 18'd40; src_en = 1;
        run_bursts(1, 100, "t5_first");
        for (int c = 0; c < 100 && beat_cnt < 5; c++) step();
        check("t5_beat5",     beat_cnt, 5);
        check("t5_bd_before", bursts_done, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        check("t5_cmd_tvalid", bus.cmd_tvalid, 0);
        check("t5_o_tvalid",   bus.o_tvalid, 0);
        check("t5_i_tready",   bus.i_tready, 0);
        check("t5_o_tlast",    bus.o_tlast, 0);
        check("t5_bursts",     bursts_done, 0);
        check("t5_cmd_tdata",  bus.cmd_tdata, 0);
        @(negedge clk);
        clear = 1'b0;
        rec_clear();
        run_cmds(1, 50, "t5_ncmd");
        if (cmd_addr_q.size() >= 1) check("t5_addr_base", cmd_addr_q[0], 32'h3000);

        // Disabled region
        do_clear();
        cfg_words = '0; fifo_occupied = 18'd40; src_en = 1;
        nc = 0; nr = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (bus.cmd_tvalid) nc++;
            if (bus.i_tready) nr++;
        end
        check("t6_no_cmd",    nc, 0);
        check("t6_no_ready",  nr, 0);
        check("t6_bursts",    bursts_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
